// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI-style slave that receives FL-bit frames, decodes the
// command MSB, and returns a read payload on MISO after a bounded wait.
// Optional frame-abort reporting on frame_err is built when SPI_SLAVE_FRAME_ERR_EN is defined.
module spi_slave_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int TX_WAIT_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  output logic [2:0]            cs,
  output logic                  frame_err,
  output logic                  tx_timeout
);
  localparam int FL = DATA_WIDTH + 2;
  localparam int CW = $clog2(FL);
  localparam int WW = $clog2(TX_WAIT_MAX + 1);
  localparam int TW = $clog2(DATA_WIDTH + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITE     = 3'd1;
  localparam logic [2:0] CHK_CMD   = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  logic [2:0]            r_state;
  logic [FL-2:0]         r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;
  logic                  r_rd_seen;
  logic                  r_wait;
  logic [WW-1:0]         r_wcnt;
  logic                  r_txact;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [TW-1:0]         r_txcnt;
  logic                  r_miso;
  logic                  r_rx_valid;
  logic [FL-1:0]         r_rx_data;
  logic                  r_to;
  logic                  w_data_st;
  logic                  w_last;
  logic                  w_abort;

  assign w_data_st = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
  assign w_last    = w_data_st && !r_done && (r_cnt == CW'(FL - 2));
  assign w_abort   = SS_n && (r_state != IDLE);

  // Frame FSM: command decode, serial shift-in, read wait window and MISO shift-out.
  always_ff @(posedge clk) begin
    r_rx_valid <= 1'b0;
    r_to       <= 1'b0;
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_rd_seen <= 1'b0;
      r_wait    <= 1'b0;
      r_wcnt    <= '0;
      r_txact   <= 1'b0;
      r_tx      <= '0;
      r_txcnt   <= '0;
      r_miso    <= 1'b0;
      r_rx_data <= '0;
    end else if (w_abort) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_wait  <= 1'b0;
      r_wcnt  <= '0;
      r_txact <= 1'b0;
      r_txcnt <= '0;
      r_miso  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (!SS_n) r_state <= CHK_CMD;
        CHK_CMD: begin
          r_shift <= {{(FL-2){1'b0}}, MOSI};
          r_cnt   <= '0;
          r_done  <= 1'b0;
          r_state <= !MOSI ? WRITE : r_rd_seen ? READ_DATA : READ_ADD;
        end
        default: ;
      endcase
      if (w_data_st && !r_done) begin
        r_shift <= {r_shift[FL-3:0], MOSI};
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_done     <= 1'b1;
          r_rx_valid <= 1'b1;
          r_rx_data  <= {r_shift, MOSI};
          if (r_state == READ_ADD) r_rd_seen <= 1'b1;
          if (r_state == READ_DATA) begin
            r_rd_seen <= 1'b0;
            r_wait    <= 1'b1;
            r_wcnt    <= '0;
          end
        end
      end
      if (r_wait) begin
        if (tx_valid) begin
          r_wait  <= 1'b0;
          r_txact <= 1'b1;
          r_miso  <= tx_data[DATA_WIDTH-1];
          r_tx    <= {tx_data[DATA_WIDTH-2:0], 1'b0};
          r_txcnt <= TW'(DATA_WIDTH - 1);
        end else if (r_wcnt == WW'(TX_WAIT_MAX - 1)) begin
          r_wait <= 1'b0;
          r_to   <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + WW'(1);
        end
      end
      if (r_txact) begin
        if (r_txcnt != '0) begin
          r_miso  <= r_tx[DATA_WIDTH-1];
          r_tx    <= {r_tx[DATA_WIDTH-2:0], 1'b0};
          r_txcnt <= r_txcnt - TW'(1);
        end else begin
          r_miso  <= 1'b0;
          r_txact <= 1'b0;
        end
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic r_ferr;
  // Flag SS_n rising before frame completion or while the payload is still shifting out.
  always_ff @(posedge clk) begin
    if (!rst_n) r_ferr <= 1'b0;
    else r_ferr <= w_abort && w_data_st && (!r_done || r_txact);
  end
  assign frame_err = r_ferr;
`else
  assign frame_err = 1'b0;
`endif

  assign cs         = r_state;
  assign MISO       = r_miso;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign tx_timeout = r_to;
endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width (legal >= 2); frame length FL = DATA_WIDTH+2.
REQ-002 SHALL have parameter TX_WAIT_MAX, default 16, maximum cycles waited for tx_valid in READ_DATA (legal >= 1).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports SS_n  in  1  slave select, active low; MOSI  in  1  serial data from master.
REQ-006 SHALL have ports tx_data  in  DATA_WIDTH  read payload; tx_valid  in  1  tx_data valid strobe.
REQ-007 SHALL have ports MISO  out  1  serial data to master; rx_data  out  FL  received frame; rx_valid  out  1  frame-complete pulse.
REQ-008 SHALL have ports cs  out  3  current state; frame_err  out  1  abort pulse; tx_timeout  out  1  wait-expired pulse.

Function
REQ-009 SHALL encode states IDLE=0, WRITE=1, CHK_CMD=2, READ_ADD=3, READ_DATA=4 on cs.
REQ-010 IDLE: SS_n=1 -> IDLE; SS_n=0 -> CHK_CMD.
REQ-011 CHK_CMD SHALL sample MOSI as frame bit FL-1 (MSB); MOSI=0 -> WRITE; MOSI=1 and rd_addr_seen=0 -> READ_ADD; MOSI=1 and rd_addr_seen=1 -> READ_DATA.
REQ-012 WRITE/READ_ADD/READ_DATA SHALL shift in the remaining FL-1 bits MSB-first, one per cycle, starting the cycle after CHK_CMD.
REQ-013 The cycle after the final bit is sampled, rx_data SHALL hold the full frame and rx_valid SHALL be 1 for exactly one cycle; rx_data holds until the next completed frame.
REQ-014 Bits after frame completion SHALL be ignored; state holds until SS_n=1.
REQ-015 Internal flag rd_addr_seen SHALL set on a completed READ_ADD frame and clear on a completed READ_DATA frame; aborted frames leave it unchanged.
REQ-016 READ_DATA after rx_valid SHALL wait for tx_valid=1, capture tx_data, and drive it MSB-first on MISO for DATA_WIDTH cycles beginning the cycle after capture.
REQ-017 tx_valid outside that wait window SHALL be ignored.
REQ-018 If tx_valid is not seen within TX_WAIT_MAX cycles after rx_valid, tx_timeout SHALL pulse one cycle and no data SHALL be shifted for that frame.
REQ-019 MISO SHALL be 0 in every cycle not carrying a payload bit.
REQ-020 SS_n=1 in any non-IDLE state SHALL return to IDLE next cycle, clearing bit and wait counters, with no rx_valid; SS_n takes priority over frame completion in the same cycle.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force cs=IDLE, MISO=0, rx_valid=0, rx_data=0, frame_err=0, tx_timeout=0, rd_addr_seen=0, counters=0, regardless of SS_n or operation in progress.

Configuration
REQ-022 Macro SPI_SLAVE_FRAME_ERR_EN defined: frame_err SHALL pulse one cycle, in the cycle after SS_n rises, when SS_n rises in WRITE/READ_ADD/READ_DATA before rx_valid or during MISO payload shifting.
REQ-023 Macro SPI_SLAVE_FRAME_ERR_EN undefined: frame_err SHALL be constant 0; all other behaviour identical.

Verification (DATA_WIDTH=8, TX_WAIT_MAX=16)
REQ-024 Drive rst_n=0 for one edge with SS_n=0 -> cs=0, MISO=0, rx_valid=0, rx_data=10'h000.
REQ-025 Hold SS_n=0 and shift 10'b00_1010_0101 -> cs 0->2->1; one-cycle rx_valid with rx_data=10'h0A5.
REQ-026 Send read frame 10'h23C, then 10'h300; then tx_valid=1 with tx_data=8'hC3 -> cs=3, then cs=4; MISO=1,1,0,0,0,0,1,1 on the 8 cycles after capture, then 0.
REQ-027 Raise SS_n after 5 bits in WRITE -> cs=IDLE next cycle, no rx_valid; frame_err=1 for one cycle when macro defined, else 0.
REQ-028 Send completed READ_DATA frame, never assert tx_valid -> tx_timeout pulses 16 cycles after rx_valid; MISO stays 0.
REQ-029 Drive rst_n=0 during MISO shifting with SS_n=0 -> next cycle cs=IDLE, MISO=0; next read frame enters READ_ADD.
